// File: rtl/decode_ctrl_seq.sv
// decode_ctrl_seq: registered RV32I(+A,+M) decoder with valid/ready handshake.
// Ports: i_instr/i_instr_valid/o_instr_ready in, o_ctrl/o_ex/o_ex_cause/o_ctrl_valid/i_ctrl_ready out, i_flush.
module decode_ctrl_seq #(
   parameter bit          EN_A    = 1'b1,
   parameter bit          EN_M    = 1'b1,
   parameter int unsigned DIV_LAT = 34,
   parameter int unsigned CNT_W   = 6
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [31:0] i_instr,
   input  logic        i_instr_valid,
   output logic        o_instr_ready,
   input  logic        i_flush,
   output logic [16:0] o_ctrl,
   output logic        o_ex,
   output logic [1:0]  o_ex_cause,
   output logic        o_ctrl_valid,
   input  logic        i_ctrl_ready
);

   typedef struct packed {
      logic       alum_en;
      logic       atomic;
      logic       csr_en;
      logic       pc4;
      logic [1:0] jump;
      logic       rw;
      logic       b;
      logic [1:0] a;
      logic [2:0] op;
      logic       m2r;
      logic       mw;
      logic       mr;
      logic       br;
   } ctrl_t;

   typedef enum logic [1:0] {RUN, AMO_WR, DIV_WAIT} state_t;

   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [11:0] f12;
   logic [6:0]  f7;

   assign opc = i_instr[6:0];
   assign rd  = i_instr[11:7];
   assign f3  = i_instr[14:12];
   assign rs1 = i_instr[19:15];
   assign f12 = i_instr[31:20];
   assign f7  = i_instr[31:25];

   ctrl_t      dec;
   logic       dec_ex;
   logic [1:0] dec_cause;
   logic       dec_amo;
   logic       dec_div;
   logic       illegal;

   always_comb begin
      dec       = '0;
      dec_ex    = 1'b0;
      dec_cause = 2'd0;
      dec_amo   = 1'b0;
      dec_div   = 1'b0;
      illegal   = 1'b0;
      unique case (opc)
         7'b0110011: begin
            dec.rw = 1'b1;
            dec.op = 3'b010;
            if (f7 == 7'b0000001) begin
               if (EN_M) begin
                  dec.op      = 3'b000;
                  dec.alum_en = 1'b1;
                  dec_div     = f3[2];
               end else begin
                  illegal = 1'b1;
               end
            end
         end
         7'b0010011: begin
            dec.b  = 1'b1;
            dec.rw = 1'b1;
            dec.op = 3'b011;
         end
         7'b0000011: begin
            dec.mr  = 1'b1;
            dec.m2r = 1'b1;
            dec.b   = 1'b1;
            dec.rw  = 1'b1;
         end
         7'b0100011: begin
            dec.mw = 1'b1;
            dec.b  = 1'b1;
         end
         7'b1100011: begin
            dec.br = 1'b1;
            dec.op = 3'b001;
         end
         7'b0110111: begin
            dec.a  = 2'd2;
            dec.b  = 1'b1;
            dec.rw = 1'b1;
            dec.op = 3'b100;
         end
         7'b0010111: begin
            dec.a  = 2'd1;
            dec.b  = 1'b1;
            dec.rw = 1'b1;
            dec.op = 3'b100;
         end
         7'b1101111: begin
            dec.rw   = 1'b1;
            dec.jump = 2'd1;
            dec.pc4  = 1'b1;
         end
         7'b1100111: begin
            dec.b    = 1'b1;
            dec.rw   = 1'b1;
            dec.op   = 3'b100;
            dec.jump = 2'd2;
            dec.pc4  = 1'b1;
         end
         7'b0001111: begin
         end
         7'b1110011: begin
            dec.rw     = 1'b1;
            dec.csr_en = 1'b1;
            if (f3 == 3'd0 && rs1 == 5'd0 && rd == 5'd0) begin
               if (f12 == 12'd0) begin
                  dec_ex    = 1'b1;
                  dec_cause = 2'd1;
               end else if (f12 == 12'd1) begin
                  dec_ex    = 1'b1;
                  dec_cause = 2'd2;
               end
            end
         end
         7'b0101111: begin
            if (EN_A) begin
               dec.atomic = 1'b1;
               dec.rw     = 1'b1;
               dec.op     = 3'b101;
               dec.mr     = 1'b1;
               dec.m2r    = 1'b1;
               if (f7[6:2] == 5'b00011) dec.mw = 1'b1;
               else if (f7[6:2] != 5'b00010) dec_amo = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
      if (i_instr[1:0] != 2'b11) illegal = 1'b1;
      if (illegal) begin
         dec       = '0;
         dec_ex    = 1'b1;
         dec_cause = 2'd0;
         dec_amo   = 1'b0;
         dec_div   = 1'b0;
      end
   end

   // Second AMO beat: the write half of the read-modify-write.
   ctrl_t beat1;
   always_comb begin
      beat1        = '0;
      beat1.atomic = 1'b1;
      beat1.op     = 3'b101;
      beat1.mw     = 1'b1;
   end

   state_t           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic             ex_q, ex_d;
   logic [1:0]       cause_q, cause_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready;
   logic             accept;
   logic             consume;

   // Gated by reset so nothing is offered as accepted while held in reset.
   assign ready = i_rstn & (state_q == RUN) & !i_flush
                & (!valid_q | i_ctrl_ready);
   assign accept  = i_instr_valid & ready;
   assign consume = valid_q & i_ctrl_ready;

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      ex_d    = ex_q;
      cause_d = cause_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (i_flush) begin
         valid_d = 1'b0;
         state_d = RUN;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            RUN: begin
               if (accept) begin
                  ctrl_d  = dec;
                  ex_d    = dec_ex;
                  cause_d = dec_cause;
                  valid_d = 1'b1;
                  if (dec_amo) begin
                     state_d = AMO_WR;
                  end else if (dec_div) begin
                     state_d = DIV_WAIT;
                     cnt_d   = DIV_INIT;
                  end
               end else if (consume) begin
                  valid_d = 1'b0;
               end
            end
            AMO_WR: begin
               if (!valid_q || i_ctrl_ready) begin
                  ctrl_d  = beat1;
                  ex_d    = 1'b0;
                  cause_d = 2'd0;
                  valid_d = 1'b1;
                  state_d = RUN;
               end
            end
            DIV_WAIT: begin
               if (consume) valid_d = 1'b0;
               if (cnt_q == '0) state_d = RUN;
               else cnt_d = cnt_q - CNT_W'(1);
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= RUN;
         ctrl_q  <= '0;
         ex_q    <= 1'b0;
         cause_q <= 2'd0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         ex_q    <= ex_d;
         cause_q <= cause_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_instr_ready = ready;
   assign o_ctrl        = ctrl_q;
   assign o_ex          = ex_q;
   assign o_ex_cause    = cause_q;
   assign o_ctrl_valid  = valid_q;

endmodule

// File: tb/tb_decode_ctrl_seq.sv
// tb_decode_ctrl_seq: directed bench for decode_ctrl_seq.
// Main instance uses DIV_LAT=4; a second instance has EN_M=0.
module tb_decode_ctrl_seq;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] instr;
   logic        ivalid;
   logic        ivalid2;
   logic        flush;
   logic        crdy;

   logic        ready, ready2;
   logic [16:0] ctrl, ctrl2;
   logic        ex, ex2;
   logic [1:0]  cause, cause2;
   logic        cvalid, cvalid2;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decode_ctrl_seq #(.EN_A(1'b1), .EN_M(1'b1), .DIV_LAT(4), .CNT_W(6)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_instr(instr), .i_instr_valid(ivalid),
      .o_instr_ready(ready), .i_flush(flush), .o_ctrl(ctrl), .o_ex(ex),
      .o_ex_cause(cause), .o_ctrl_valid(cvalid), .i_ctrl_ready(crdy)
   );

   decode_ctrl_seq #(.EN_A(1'b1), .EN_M(1'b0), .DIV_LAT(4), .CNT_W(6)) dut_nm (
      .i_clk(clk), .i_rstn(rstn), .i_instr(instr), .i_instr_valid(ivalid2),
      .o_instr_ready(ready2), .i_flush(flush), .o_ctrl(ctrl2), .o_ex(ex2),
      .o_ex_cause(cause2), .o_ctrl_valid(cvalid2), .i_ctrl_ready(1'b1)
   );

   localparam logic [31:0] ADDI  = 32'h00500093;
   localparam logic [31:0] ADD   = 32'h00B50533;
   localparam logic [31:0] LW    = 32'h0005A503;
   localparam logic [31:0] SW    = 32'h00B52023;
   localparam logic [31:0] AMOAD = 32'h00B5202F;
   localparam logic [31:0] SCW   = 32'h18B5202F;
   localparam logic [31:0] DIV   = 32'h02B54533;
   localparam logic [31:0] MUL   = 32'h02B50533;
   localparam logic [31:0] ECALL = 32'h00000073;
   localparam logic [31:0] EBRK  = 32'h00100073;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstn    = 1'b0;
      instr   = ADDI;
      ivalid  = 1'b1;
      ivalid2 = 1'b0;
      flush   = 1'b0;
      crdy    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_valid", 32'(cvalid), 32'h0);
      chk("rst_ctrl", 32'(ctrl), 32'h0);
      chk("rst_ex", 32'(ex), 32'h0);
      chk("rst_cause", 32'(cause), 32'h0);

      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rel_ready", 32'(ready), 32'h1);
      tick;
      chk("addi_valid", 32'(cvalid), 32'h1);
      chk("addi_ctrl", 32'(ctrl), 32'h00630);
      chk("addi_ex", 32'(ex), 32'h0);

      instr = ADD;
      tick;
      chk("add_ctrl", 32'(ctrl), 32'h00420);
      instr = LW;
      tick;
      chk("lw_ctrl", 32'(ctrl), 32'h0060A);
      chk("lw_valid", 32'(cvalid), 32'h1);
      instr = SW;
      tick;
      chk("sw_ctrl", 32'(ctrl), 32'h00204);
      crdy  = 1'b0;
      instr = ADD;
      #1;
      chk("stall_ready0", 32'(ready), 32'h0);
      tick;
      chk("stall_ctrl0", 32'(ctrl), 32'h00204);
      chk("stall_valid0", 32'(cvalid), 32'h1);
      tick;
      chk("stall_ctrl1", 32'(ctrl), 32'h00204);
      chk("stall_ready1", 32'(ready), 32'h0);
      crdy   = 1'b1;
      ivalid = 1'b0;
      tick;
      chk("drain_valid", 32'(cvalid), 32'h0);

      instr  = AMOAD;
      ivalid = 1'b1;
      crdy   = 1'b0;
      tick;
      chk("amo_b0_ctrl", 32'(ctrl), 32'h0845A);
      chk("amo_b0_valid", 32'(cvalid), 32'h1);
      chk("amo_wr_ready", 32'(ready), 32'h0);
      ivalid = 1'b0;
      tick;
      chk("amo_b0_hold", 32'(ctrl), 32'h0845A);
      crdy = 1'b1;
      tick;
      chk("amo_b1_ctrl", 32'(ctrl), 32'h08054);
      chk("amo_b1_valid", 32'(cvalid), 32'h1);
      chk("amo_b1_ready", 32'(ready), 32'h1);
      tick;
      chk("amo_drain", 32'(cvalid), 32'h0);

      instr  = SCW;
      ivalid = 1'b1;
      tick;
      chk("sc_ctrl", 32'(ctrl), 32'h0845E);
      ivalid = 1'b0;
      tick;
      chk("sc_single", 32'(cvalid), 32'h0);

      instr  = DIV;
      ivalid = 1'b1;
      tick;
      chk("div_ctrl", 32'(ctrl), 32'h10400);
      chk("div_ready_c0", 32'(ready), 32'h0);
      ivalid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         tick;
         chk($sformatf("div_ready_c%0d", i), 32'(ready), 32'h0);
      end
      chk("div_consumed", 32'(cvalid), 32'h0);
      tick;
      chk("div_ready_end", 32'(ready), 32'h1);

      instr  = ECALL;
      ivalid = 1'b1;
      tick;
      chk("ecall_ex", 32'(ex), 32'h1);
      chk("ecall_cause", 32'(cause), 32'h1);
      chk("ecall_ctrl", 32'(ctrl), 32'h04400);
      instr = EBRK;
      tick;
      chk("ebrk_ex", 32'(ex), 32'h1);
      chk("ebrk_cause", 32'(cause), 32'h2);
      instr = 32'hFFFF_FFFF;
      tick;
      chk("ill_ex", 32'(ex), 32'h1);
      chk("ill_cause", 32'(cause), 32'h0);
      chk("ill_ctrl", 32'(ctrl), 32'h0);
      instr = MUL;
      tick;
      chk("mul_ctrl", 32'(ctrl), 32'h10400);
      chk("mul_ex", 32'(ex), 32'h0);
      chk("mul_ready", 32'(ready), 32'h1);
      ivalid = 1'b0;
      tick;

      crdy   = 1'b0;
      instr  = AMOAD;
      ivalid = 1'b1;
      tick;
      chk("famo_valid", 32'(cvalid), 32'h1);
      ivalid = 1'b0;
      flush  = 1'b1;
      #1;
      chk("famo_rdy_fl", 32'(ready), 32'h0);
      tick;
      chk("famo_killed", 32'(cvalid), 32'h0);
      flush = 1'b0;
      #1;
      chk("famo_ready", 32'(ready), 32'h1);
      tick;
      chk("famo_no_b1", 32'(cvalid), 32'h0);
      crdy = 1'b1;

      instr  = DIV;
      ivalid = 1'b1;
      tick;
      ivalid = 1'b0;
      tick;
      chk("fdiv_wait", 32'(ready), 32'h0);
      flush = 1'b1;
      tick;
      chk("fdiv_valid", 32'(cvalid), 32'h0);
      flush = 1'b0;
      #1;
      chk("fdiv_ready", 32'(ready), 32'h1);
      tick;

      instr   = MUL;
      ivalid2 = 1'b1;
      tick;
      ivalid2 = 1'b0;
      chk("nom_valid", 32'(cvalid2), 32'h1);
      chk("nom_ex", 32'(ex2), 32'h1);
      chk("nom_cause", 32'(cause2), 32'h0);
      chk("nom_ctrl", 32'(ctrl2), 32'h0);

      crdy   = 1'b0;
      instr  = AMOAD;
      ivalid = 1'b1;
      tick;
      ivalid = 1'b0;
      rstn   = 1'b0;
      #1;
      chk("rmid_valid", 32'(cvalid), 32'h0);
      chk("rmid_ready", 32'(ready), 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      crdy = 1'b1;
      tick;
      chk("rmid_no_b1", 32'(cvalid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
